uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer sitting directly upstream of the UART transmitter in `top`. Accepts `WORD_LENGTH`-bit words from a host write port, stores them in a circular FIFO, and drives the transmitter's `UART_Tx_RQST`/`Tx_DATA` request, pacing itself on `UART_Tx_READY_BUSY`. This lets the host burst several words without waiting for each serial frame to complete.

## Interface
- `DEPTH`, default 16: number of FIFO entries; must be a power of two, ≥ 2.
- `AW`, default `$clog2(DEPTH)`: pointer width (derived, do not override).
- `t_clk`  input  1: transmit-domain clock, the same clock as the UART transmitter.
- `t_rst`  input  1: asynchronous, active-low reset (0 = reset).
- `wr_en`  input  1: host write strobe, sampled on the rising edge.
- `wr_data`  input  `WORD_LENGTH`: host write data.
- `full`  output  1: FIFO holds `DEPTH` words.
- `empty`  output  1: FIFO holds 0 words.
- `count`  output  AW+1: current occupancy, 0..DEPTH.
- `UART_Tx_RQST`  output  1: transmit request to the UART transmitter.
- `Tx_DATA`  output  `WORD_LENGTH`: word presented to the transmitter.
- `UART_Tx_READY_BUSY`  input  1: transmitter status; 1 = ready/idle, 0 = busy.
- `ovf`  output  1: sticky overflow flag (present only with `UART_TX_FIFO_OVF_EN`).
- `ovf_clr`  input  1: clears `ovf` (present only with `UART_TX_FIFO_OVF_EN`).

## Operation
- Storage is `DEPTH` × `WORD_LENGTH` registers, with `wr_ptr` and `rd_ptr` each AW bits wide.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - `count` is tracked separately. `full = (count == DEPTH)` and `empty = (count == 0)`.
- **Push:** `wr_en && !full` writes `wr_data` at `wr_ptr`, increments `wr_ptr`, and increments `count`.
  - `wr_en` while `full` is dropped: no pointer or data change.
  - It is dropped even if a pop occurs in the same cycle, because `full` is evaluated from pre-edge state.
- The FSM has three states: IDLE, REQ, BUSY.
- **IDLE:** when `!empty && UART_Tx_READY_BUSY`, the FSM performs a pop:
  - `Tx_DATA <= mem[rd_ptr]`, `rd_ptr++`, `count--`.
  - `UART_Tx_RQST <= 1`, then go to REQ.
- **REQ:** `UART_Tx_RQST` and `Tx_DATA` are held stable.
  - When `UART_Tx_READY_BUSY == 0` (the transmitter has accepted the word): `UART_Tx_RQST <= 0`, go to BUSY.
- **BUSY:** wait for `UART_Tx_READY_BUSY == 1`, then go to IDLE.
- `Tx_DATA` retains the last popped word outside REQ.
- **Simultaneous push and pop:** both take effect; `count` is unchanged; both pointers advance.
- **Reset (asynchronous, any state, including mid-frame):**
  - Pointers, `count`, and `Tx_DATA` go to 0; FIFO contents are discarded.
  - FSM goes to IDLE; `UART_Tx_RQST = 0`.
  - `ovf = 0` when the overflow feature is compiled in.
  - Memory array contents need not be reset.

## Timing
- Reset values: `full = 0`, `empty = 1`, `count = 0`, `UART_Tx_RQST = 0`, `Tx_DATA = 0`, `ovf = 0`.
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- **Write-to-request latency:** a write on edge N into an empty FIFO with the transmitter ready gives `empty = 0` after edge N and `UART_Tx_RQST = 1` after edge N+1.
- **Request/acknowledge:**
  - `UART_Tx_RQST` falls on the first edge at which `UART_Tx_READY_BUSY` is sampled 0 while in REQ.
  - The next request cannot rise earlier than one edge after `UART_Tx_READY_BUSY` is sampled 1 in BUSY.
- The minimum spacing between consecutive requests is therefore 3 cycles plus the transmitter busy time.
- **Throughput:** the host may write one word per cycle until `full`.

## Configuration
- Macro: `UART_TX_FIFO_OVF_EN`.
- **Defined:**
  - `ovf` and `ovf_clr` ports exist.
  - `ovf` sets on any edge where `wr_en && full`.
  - `ovf_clr` clears `ovf`; set has priority if both occur in the same cycle.
- **Undefined:** neither port exists; dropped writes are silent. All other behaviour is identical.

## Test plan
- **Reset:** assert `t_rst = 0` mid-REQ with 3 words queued → asynchronously `UART_Tx_RQST = 0`, `count = 0`, `empty = 1`; after release the FSM is in IDLE with no request.
- **Single word:** write 0xA5 with `UART_Tx_READY_BUSY = 1` → `UART_Tx_RQST = 1` with `Tx_DATA = 0xA5` two edges after the write; drive READY_BUSY low → RQST drops on the next edge; `count = 0`.
- **Ordering and wrap:** write 20 words 0x00..0x13 at `DEPTH = 16` while the bench transmitter model consumes them (busy 10 cycles each) → `Tx_DATA` sequence is exactly 0x00..0x13, with no loss, across a pointer wrap.
- **Full/overflow:** with the transmitter held busy, write 17 words → `full = 1` after the 16th write, `count = 16`; the 17th write is dropped; with `UART_TX_FIFO_OVF_EN` defined, `ovf = 1` until `ovf_clr` is pulsed.
- **Simultaneous push/pop:** `count = 5`, write on the same edge as an IDLE pop → `count` stays 5; the popped word is the oldest entry.
- **Handshake hold:** keep `UART_Tx_READY_BUSY = 1` for 8 cycles while in REQ → `UART_Tx_RQST` and `Tx_DATA` stay stable for all 8 cycles; no second pop occurs.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO feeding the UART transmitter with a REQ/BUSY handshake.
// Optional sticky overflow flag (ovf/ovf_clr) compiled in with `UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                   t_clk,
  input  logic                   t_rst,
  input  logic                   wr_en,
  input  logic [WORD_LENGTH-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   UART_Tx_RQST,
  output logic [WORD_LENGTH-1:0] Tx_DATA,
  input  logic                   UART_Tx_READY_BUSY
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                   ovf,
  input  logic                   ovf_clr
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t                 state;
  logic [WORD_LENGTH-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   push, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty && UART_Tx_READY_BUSY;

  // Storage carries no reset; stale words are unreachable once count is cleared.
  always_ff @(posedge t_clk)
    if (push) mem[wr_ptr] <= wr_data;

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state        <= IDLE;
      UART_Tx_RQST <= 1'b0;
      Tx_DATA      <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          Tx_DATA      <= mem[rd_ptr];
          UART_Tx_RQST <= 1'b1;
          state        <= REQ;
        end
        // Transmitter going busy is the acceptance of the held word.
        REQ: if (!UART_Tx_READY_BUSY) begin
          UART_Tx_RQST <= 1'b0;
          state        <= BUSY;
        end
        BUSY: if (UART_Tx_READY_BUSY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst)             ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
    else if (ovf_clr)       ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_uart_tx_fifo;
  localparam int W = 8, DEPTH = 16, AW = 4;

  logic t_clk = 1'b0, t_rst = 1'b1, wr_en = 1'b0, rdy = 1'b1;
  logic [W-1:0] wr_data = '0;
  logic full, empty, rq;
  logic [AW:0] count;
  logic [W-1:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf, ovf_clr = 1'b0;
`endif

  always #5 t_clk = ~t_clk;

  uart_tx_fifo #(.WORD_LENGTH(W), .DEPTH(DEPTH)) dut (
    .t_clk(t_clk), .t_rst(t_rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count),
    .UART_Tx_RQST(rq), .Tx_DATA(tx_data), .UART_Tx_READY_BUSY(rdy)
`ifdef UART_TX_FIFO_OVF_EN
    , .ovf(ovf), .ovf_clr(ovf_clr)
`endif
  );

  int n_vec = 0, n_err = 0;

  // model: words waiting, word on offer, whether a request is outstanding,
  // whether an accepted word is still being shifted out
  logic [W-1:0] q[$];
  logic [W-1:0] m_data = '0;
  bit m_rq = 0, m_wait = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); m_data = '0; m_rq = 0; m_wait = 0; m_ovf = 0;
  endtask

  // One clock: apply inputs, advance the model, check every output after the edge.
  task automatic cyc(input bit w, input logic [W-1:0] d, input bit r);
    bit was_full, pop;
    wr_en = w; wr_data = d; rdy = r;
    was_full = (q.size() == DEPTH);
    pop = !m_rq && !m_wait && (q.size() > 0) && r;
`ifdef UART_TX_FIFO_OVF_EN
    if (w && was_full) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
`endif
    if (m_rq && !r) begin m_rq = 0; m_wait = 1; end
    else if (m_wait && r) m_wait = 0;
    if (pop) begin m_data = q.pop_front(); m_rq = 1; end
    if (w && !was_full) q.push_back(d);
    @(posedge t_clk); #1;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("rqst", rq, m_rq);
    chk("tx_data", tx_data, m_data);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf", ovf, m_ovf);
`endif
  endtask

  // Let the transmitter accept everything pending and return the FSM to idle.
  task automatic drain();
    int c = 0;
    while ((q.size() > 0 || m_rq || m_wait) && c < 400) begin
      cyc(0, '0, !m_rq);
      c++;
    end
    chk("drain_timeout", c >= 400, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got[$];
    int idx, bc, ad;
    bit prev_rq, w, r;

    // reset values
    t_rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rqst", rq, 0);
    chk("rst_data", tx_data, 0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    repeat (2) @(posedge t_clk);
    #1 t_rst = 1'b1;

    // single word: request two edges after the write
    cyc(1, 8'hA5, 1);
    chk("sw_empty", empty, 0);
    chk("sw_rq_n", rq, 0);
    cyc(0, '0, 1);
    chk("sw_rq", rq, 1);
    chk("sw_data", tx_data, 8'hA5);
    cyc(0, '0, 0);
    chk("sw_rq_drop", rq, 0);
    chk("sw_count", count, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 1);

    // handshake hold: ready stays high in REQ, nothing else pops
    cyc(1, 8'h3C, 1);
    cyc(1, 8'h77, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, 1);
      chk("hold_rq", rq, 1);
      chk("hold_data", tx_data, 8'h3C);
      chk("hold_count", count, 1);
    end
    drain();

    // ordering and wrap: 20 words through a 10-cycle-busy transmitter
    idx = 0; bc = 0; prev_rq = rq; got.delete();
    for (int c = 0; c < 800 && got.size() < 20; c++) begin
      r = 1;
      if (bc > 0) begin r = 0; bc--; end
      else if (rq) begin r = 0; bc = 9; end
      w = (idx < 20) && (q.size() < DEPTH);
      cyc(w, W'(idx), r);
      if (w) idx++;
      if (rq && !prev_rq) got.push_back(tx_data);
      prev_rq = rq;
    end
    chk("wrap_n", got.size(), 20);
    for (int i = 0; i < got.size(); i++) chk("wrap_word", got[i], i);
    drain();

    // full and overflow with transmitter busy
    for (int i = 1; i <= 17; i++) begin
      cyc(1, W'(8'h80 + i), 0);
      if (i == 16) begin
        chk("full16", full, 1);
        chk("count16", count, 16);
      end
    end
    chk("drop17_count", count, 16);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", ovf, 1);
    repeat (3) cyc(0, '0, 0);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    cyc(0, '0, 0);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
`endif
    drain();

    // simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) cyc(1, W'(8'h50 + i), 0);
    cyc(1, 8'hEE, 1);
    chk("pp_count", count, 5);
    chk("pp_oldest", tx_data, 8'h50);
    drain();

    // asynchronous reset mid-REQ with 3 words queued
    for (int i = 0; i < 4; i++) cyc(1, W'(8'h60 + i), 0);
    cyc(0, '0, 1);
    chk("pre_rst_rq", rq, 1);
    chk("pre_rst_count", count, 3);
    t_rst = 1'b0;
    #2;
    chk("arst_rq", rq, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_data", tx_data, 0);
    model_reset();
    @(posedge t_clk); #1;
    t_rst = 1'b1;
    repeat (3) cyc(0, '0, 1);

    // random traffic
    bc = 0; ad = 0;
    for (int c = 0; c < 2500; c++) begin
      if (bc > 0) begin r = 0; bc--; end
      else if (rq) begin
        if (ad > 0) begin r = 1; ad--; end
        else begin r = 0; bc = $urandom_range(1, 8); ad = $urandom_range(0, 3); end
      end
      else r = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 99) < 60);
`ifdef UART_TX_FIFO_OVF_EN
      ovf_clr = ($urandom_range(0, 31) == 0);
`endif
      cyc(w, W'($urandom), r);
    end
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
